// File: rtl/uart_rx_frame_if.sv
// Receive-side holding register bus: frame data and status from the UART
// receiver (master) to the consuming parser (slave), with ready back-pressure.
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_RX_Ready;
  logic                 o_RX_DV;
  logic [DATA_BITS-1:0] o_RX_Data;
  logic                 o_Parity_Err;
  logic                 o_Frame_Err;
  logic                 o_Break;
  logic                 o_Overrun;

  modport master (
    input  i_RX_Ready,
    output o_RX_DV, o_RX_Data, o_Parity_Err, o_Frame_Err, o_Break, o_Overrun
  );

  modport slave (
    output i_RX_Ready,
    input  o_RX_DV, o_RX_Data, o_Parity_Err, o_Frame_Err, o_Break, o_Overrun
  );
endinterface

// File: rtl/uart_rx_frame.sv
// Parameterised UART receiver: 2-flop synchroniser, 3-sample majority vote,
// optional parity, 1/2 stop bits, framing/break detection, and a valid/ready
// holding register that reports frames dropped while it is still occupied.
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            i_Clock,
  input  logic            i_Rst_L,
  input  logic            i_RX_Serial,
  uart_rx_frame_if.master rx_if
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam int HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] C_S0   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] C_S1   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] C_RES  = CNT_W'(HALF + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] L_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] L_STOP = IDX_W'(STOP_BITS - 1);
  localparam logic             ODD    = (PARITY_MODE == 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BRK_WAIT
  } state_t;

  state_t               r_State, w_State_Next;
  logic [1:0]           r_Sync;
  logic [1:0]           r_Samp;
  logic [CNT_W-1:0]     r_Cnt;
  logic [IDX_W-1:0]     r_Idx;
  logic [DATA_BITS-1:0] r_Shift;
  logic                 r_Par_Bit, r_Perr, r_Ferr;

  logic                 r_DV, r_Overrun, r_Out_Perr, r_Out_Ferr, r_Out_Brk;
  logic [DATA_BITS-1:0] r_Out_Data;

  logic w_Rxs, w_Maj, w_Res, w_Last;
  logic w_Cnt_Clr, w_Idx_Clr, w_Idx_Inc, w_Done, w_Brk, w_Ferr_Final;

  assign w_Rxs  = r_Sync[1];
  assign w_Maj  = (r_Samp[0] & r_Samp[1]) | (r_Samp[0] & w_Rxs) | (r_Samp[1] & w_Rxs);
  assign w_Res  = (r_Cnt == C_RES);
  assign w_Last = (r_Cnt == C_LAST);

  // Bring the asynchronous line into the clock domain (idle-high reset value)
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) r_Sync <= 2'b11;
    else          r_Sync <= {r_Sync[0], i_RX_Serial};
  end

  // State register
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) r_State <= IDLE;
    else          r_State <= w_State_Next;
  end

  // Next-state and datapath strobes; the last stop bit completes the frame
  // at its majority point rather than at the end of the bit, for early resync
  always_comb begin
    w_State_Next = r_State;
    w_Cnt_Clr    = 1'b0;
    w_Idx_Clr    = 1'b0;
    w_Idx_Inc    = 1'b0;
    w_Done       = 1'b0;
    w_Brk        = 1'b0;
    w_Ferr_Final = r_Ferr | ~w_Maj;
    case (r_State)
      IDLE: begin
        w_Cnt_Clr = 1'b1;
        if (!w_Rxs) w_State_Next = START;
      end
      START: begin
        if (w_Res && w_Maj) begin
          w_State_Next = IDLE;
          w_Cnt_Clr    = 1'b1;
        end else if (w_Last) begin
          w_State_Next = DATA;
          w_Cnt_Clr    = 1'b1;
          w_Idx_Clr    = 1'b1;
        end
      end
      DATA: begin
        if (w_Last) begin
          w_Cnt_Clr = 1'b1;
          if (r_Idx == L_DATA) begin
            w_Idx_Clr    = 1'b1;
            w_State_Next = (PARITY_MODE != 0) ? PARITY : STOP;
          end else begin
            w_Idx_Inc = 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_Last) begin
          w_Cnt_Clr    = 1'b1;
          w_State_Next = STOP;
        end
      end
      STOP: begin
        if (w_Res && (r_Idx == L_STOP)) begin
          w_Done       = 1'b1;
          w_Cnt_Clr    = 1'b1;
          w_Brk        = (r_Shift == '0) && !r_Par_Bit && w_Ferr_Final;
          w_State_Next = w_Brk ? BRK_WAIT : IDLE;
        end else if (w_Last) begin
          w_Cnt_Clr = 1'b1;
          w_Idx_Inc = 1'b1;
        end
      end
      BRK_WAIT: begin
        w_Cnt_Clr = 1'b1;
        if (w_Rxs) w_State_Next = IDLE;
      end
      default: w_State_Next = IDLE;
    endcase
  end

  // Bit timing, majority samples, data shift and per-frame error accumulation
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Cnt     <= '0;
      r_Idx     <= '0;
      r_Samp    <= '0;
      r_Shift   <= '0;
      r_Par_Bit <= 1'b0;
      r_Perr    <= 1'b0;
      r_Ferr    <= 1'b0;
    end else begin
      r_Cnt <= w_Cnt_Clr ? '0 : r_Cnt + 1'b1;
      if (w_Idx_Clr)      r_Idx <= '0;
      else if (w_Idx_Inc) r_Idx <= r_Idx + 1'b1;
      if (r_Cnt == C_S0) r_Samp[0] <= w_Rxs;
      if (r_Cnt == C_S1) r_Samp[1] <= w_Rxs;
      if (r_State == IDLE) begin
        r_Par_Bit <= 1'b0;
        r_Perr    <= 1'b0;
        r_Ferr    <= 1'b0;
      end
      if (w_Res) begin
        case (r_State)
          DATA:    r_Shift <= {w_Maj, r_Shift[DATA_BITS-1:1]};
          PARITY: begin
            r_Par_Bit <= w_Maj;
            r_Perr    <= (^{r_Shift, w_Maj}) ^ ODD;
          end
          STOP:    if (!w_Maj) r_Ferr <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Holding register: load when empty or being drained this cycle, else drop and flag overrun
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_DV       <= 1'b0;
      r_Overrun  <= 1'b0;
      r_Out_Data <= '0;
      r_Out_Perr <= 1'b0;
      r_Out_Ferr <= 1'b0;
      r_Out_Brk  <= 1'b0;
    end else begin
      r_Overrun <= 1'b0;
      if (w_Done) begin
        if (!r_DV || rx_if.i_RX_Ready) begin
          r_DV       <= 1'b1;
          r_Out_Data <= r_Shift;
          r_Out_Perr <= r_Perr;
          r_Out_Ferr <= w_Ferr_Final;
          r_Out_Brk  <= w_Brk;
        end else begin
          r_Overrun <= 1'b1;
        end
      end else if (r_DV && rx_if.i_RX_Ready) begin
        r_DV <= 1'b0;
      end
    end
  end

  assign rx_if.o_RX_DV      = r_DV;
  assign rx_if.o_RX_Data    = r_Out_Data;
  assign rx_if.o_Parity_Err = r_Out_Perr;
  assign rx_if.o_Frame_Err  = r_Out_Ferr;
  assign rx_if.o_Break      = r_Out_Brk;
  assign rx_if.o_Overrun    = r_Overrun;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: three configurations (8N1, 7E1, 8N2) at 16 clocks
// per bit, scoreboard of expected frames popped on each accepted handshake.
module tb_uart_rx_frame;

  localparam int CPB = 16;

  typedef struct {
    int         id;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic [2:0] r_Line = 3'b111;
  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         dv_cyc[3];
  int         ovr_cyc[3];

  always #5 clk = ~clk;

  uart_rx_frame_if #(.DATA_BITS(8)) a_if ();
  uart_rx_frame_if #(.DATA_BITS(7)) b_if ();
  uart_rx_frame_if #(.DATA_BITS(8)) c_if ();

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_a (
    .i_Clock(clk), .i_Rst_L(rst_l), .i_RX_Serial(r_Line[0]), .rx_if(a_if.master));
  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1)) u_b (
    .i_Clock(clk), .i_Rst_L(rst_l), .i_RX_Serial(r_Line[1]), .rx_if(b_if.master));
  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_c (
    .i_Clock(clk), .i_Rst_L(rst_l), .i_RX_Serial(r_Line[2]), .rx_if(c_if.master));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input logic [8:0] d, input logic pe, input logic fe, input logic bk);
    exp_t e;
    e.id = id; e.data = d; e.perr = pe; e.ferr = fe; e.brk = bk;
    sb.push_back(e);
  endtask

  task automatic accept(input int id, input logic [8:0] d, input logic pe, input logic fe, input logic bk);
    exp_t e;
    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("dut_id", id, e.id);
      check($sformatf("data[%0d]", id), d, e.data);
      check($sformatf("perr[%0d]", id), pe, e.perr);
      check($sformatf("ferr[%0d]", id), fe, e.ferr);
      check($sformatf("brk[%0d]", id), bk, e.brk);
    end
  endtask

  // Passive monitors: count DV/overrun cycles and score every accepted frame
  always @(negedge clk) begin
    if (a_if.o_RX_DV)   dv_cyc[0]++;
    if (a_if.o_Overrun) ovr_cyc[0]++;
    if (a_if.o_RX_DV && a_if.i_RX_Ready)
      accept(0, 9'(a_if.o_RX_Data), a_if.o_Parity_Err, a_if.o_Frame_Err, a_if.o_Break);
  end
  always @(negedge clk) begin
    if (b_if.o_RX_DV)   dv_cyc[1]++;
    if (b_if.o_Overrun) ovr_cyc[1]++;
    if (b_if.o_RX_DV && b_if.i_RX_Ready)
      accept(1, 9'(b_if.o_RX_Data), b_if.o_Parity_Err, b_if.o_Frame_Err, b_if.o_Break);
  end
  always @(negedge clk) begin
    if (c_if.o_RX_DV)   dv_cyc[2]++;
    if (c_if.o_Overrun) ovr_cyc[2]++;
    if (c_if.o_RX_DV && c_if.i_RX_Ready)
      accept(2, 9'(c_if.o_RX_Data), c_if.o_Parity_Err, c_if.o_Frame_Err, c_if.o_Break);
  end

  function automatic logic [31:0] a_outs();
    return 32'({a_if.o_RX_DV, a_if.o_RX_Data, a_if.o_Parity_Err, a_if.o_Frame_Err,
                a_if.o_Break, a_if.o_Overrun});
  endfunction

  // Drives one frame cycle by cycle; par_bit < 0 means no parity bit,
  // spike_at inverts one line cycle, rst_at asserts reset at that cycle and aborts
  task automatic send_frame(input int id, input logic [8:0] data, input int nbits,
                            input int par_bit, input int nstop, input logic [1:0] stop_vals,
                            input int spike_at, input int rst_at);
    int np;
    int nb;
    np = (par_bit >= 0) ? 1 : 0;
    nb = 1 + nbits + np + nstop;
    for (int j = 0; j < nb * CPB; j++) begin
      int   k;
      logic v;
      k = j / CPB;
      if (k == 0)                     v = 1'b0;
      else if (k <= nbits)            v = data[k-1];
      else if (np == 1 && k == nbits + 1) v = par_bit[0];
      else                            v = stop_vals[k - nbits - 1 - np];
      if (j == spike_at) v = ~v;
      if (j == rst_at) begin
        r_Line[id] = 1'b1;
        rst_l = 1'b0;
        #1;
        check("rst_abort_outs", a_outs(), 32'd0);
        repeat (4) @(posedge clk);
        #1 rst_l = 1'b1;
        return;
      end
      r_Line[id] = v;
      @(posedge clk);
      #1;
    end
    r_Line[id] = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    repeat (n * CPB) @(posedge clk);
    #1;
  endtask

  initial begin
    int d0;
    a_if.i_RX_Ready = 1'b1;
    b_if.i_RX_Ready = 1'b1;
    c_if.i_RX_Ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a", a_outs(), 32'd0);
    check("rst_b", 32'({b_if.o_RX_DV, b_if.o_RX_Data, b_if.o_Parity_Err, b_if.o_Frame_Err,
                        b_if.o_Break, b_if.o_Overrun}), 32'd0);
    check("rst_c", 32'({c_if.o_RX_DV, c_if.o_RX_Data, c_if.o_Parity_Err, c_if.o_Frame_Err,
                        c_if.o_Break, c_if.o_Overrun}), 32'd0);
    rst_l = 1'b1;
    idle_bits(1);

    // 8N1 back-to-back frames, ready held high: one DV cycle each
    d0 = dv_cyc[0];
    push(0, 9'h0A5, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h0A5, 8, -1, 1, 2'b11, -1, -1);
    push(0, 9'h03C, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h03C, 8, -1, 1, 2'b11, -1, -1);
    idle_bits(2);
    check("dv_one_cycle_each", dv_cyc[0] - d0, 2);

    // 7E1: correct parity bit, then forced wrong
    push(1, 9'h055, 1'b0, 1'b0, 1'b0);
    send_frame(1, 9'h055, 7, 0, 1, 2'b11, -1, -1);
    push(1, 9'h055, 1'b1, 1'b0, 1'b0);
    send_frame(1, 9'h055, 7, 1, 1, 2'b11, -1, -1);
    idle_bits(2);

    // Short low pulse must be rejected as a glitch
    d0 = dv_cyc[0];
    r_Line[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 r_Line[0] = 1'b1;
    idle_bits(3);
    check("glitch_no_dv", dv_cyc[0] - d0, 0);

    // One-cycle inversion on the centre sample of data bit 2 is outvoted
    push(0, 9'h0A5, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h0A5, 8, -1, 1, 2'b11, 3 * CPB + 1 + CPB / 2, -1);
    idle_bits(2);

    // 8N2: second stop bit low -> framing error without break
    push(2, 9'h081, 1'b0, 1'b1, 1'b0);
    send_frame(2, 9'h081, 8, -1, 2, 2'b01, -1, -1);
    idle_bits(2);

    // Break: line low for 20 bit times, exactly one frame until the line recovers
    d0 = dv_cyc[2];
    push(2, 9'h000, 1'b0, 1'b1, 1'b1);
    r_Line[2] = 1'b0;
    idle_bits(20);
    check("break_single_dv", dv_cyc[2] - d0, 1);
    r_Line[2] = 1'b1;
    idle_bits(3);
    check("break_no_more_dv", dv_cyc[2] - d0, 1);
    push(2, 9'h042, 1'b0, 1'b0, 1'b0);
    send_frame(2, 9'h042, 8, -1, 2, 2'b11, -1, -1);
    idle_bits(2);

    // Overrun: second frame dropped while first is held
    a_if.i_RX_Ready = 1'b0;
    d0 = ovr_cyc[0];
    push(0, 9'h011, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h011, 8, -1, 1, 2'b11, -1, -1);
    idle_bits(1);
    check("no_ovr_first", ovr_cyc[0] - d0, 0);
    send_frame(0, 9'h022, 8, -1, 1, 2'b11, -1, -1);
    idle_bits(1);
    check("ovr_one_pulse", ovr_cyc[0] - d0, 1);
    check("held_data", 32'(a_if.o_RX_Data), 32'h11);
    a_if.i_RX_Ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("dv_cleared", 32'(a_if.o_RX_DV), 32'd0);
    push(0, 9'h033, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h033, 8, -1, 1, 2'b11, -1, -1);
    idle_bits(2);

    // Reset during data bit 4 with a frame already held
    a_if.i_RX_Ready = 1'b0;
    send_frame(0, 9'h077, 8, -1, 1, 2'b11, -1, -1);
    idle_bits(1);
    check("pre_rst_dv", 32'(a_if.o_RX_DV), 32'd1);
    send_frame(0, 9'h099, 8, -1, 1, 2'b11, -1, 5 * CPB + CPB / 2);
    a_if.i_RX_Ready = 1'b1;
    idle_bits(2);
    check("post_rst_dv", 32'(a_if.o_RX_DV), 32'd0);
    push(0, 9'h05A, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h05A, 8, -1, 1, 2'b11, -1, -1);
    idle_bits(3);

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Parameterised UART receiver, successor to the fixed 8N1 receiver. Supports configurable data width, parity mode and stop-bit count. Adds a 2-flop input synchroniser, 3-sample majority voting, and detection of parity errors, framing errors and break conditions. Received frames are presented on a valid/ready holding register with overrun reporting, for use by packet/command parsers on the FPGA host link.

Parameters:
CLKS_PER_BIT, 217, clock cycles per bit (i_Clock freq / baud); legal range >= 8
DATA_BITS, 8, data bits per frame; legal range 5..9, sent LSB first
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
i_Clock  in  1  system clock
i_Rst_L  in  1  asynchronous active-low reset
i_RX_Serial  in  1  asynchronous serial line, idle high
i_RX_Ready  in  1  consumer accepts the held frame
o_RX_DV  out  1  frame held and valid; stays high until accepted
o_RX_Data  out  DATA_BITS  received data
o_Parity_Err  out  1  parity mismatch for the held frame (0 if PARITY_MODE=0)
o_Frame_Err  out  1  any stop bit sampled 0 for the held frame
o_Break  out  1  held frame is a break
o_Overrun  out  1  one-cycle pulse: a completed frame was dropped

Behaviour:
- Reset and clock: reset i_Rst_L, asynchronous, active-low; clock i_Clock.
- Reset values: all outputs 0; synchroniser flops 1; FSM in IDLE; counters 0.
- Reset asserted mid-frame aborts the frame immediately; nothing is delivered.
- Synchroniser: 2 flops; rxs = synchronised line; adds 2 cycles of latency.
- HALF = CLKS_PER_BIT/2 (integer division).
- Bit counter cnt runs 0..CLKS_PER_BIT-1 within each bit period.
- Sampling: rxs is sampled at cnt = HALF-1, HALF and HALF+1. The bit value is the majority of the 3 samples, resolved at cnt = HALF+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- IDLE -> START when rxs = 0; cnt = 0 on that cycle.
- START: if the majority is 1, return to IDLE at cnt = HALF+1 (glitch rejection). Otherwise go to DATA when cnt reaches CLKS_PER_BIT-1.
- DATA: shift in DATA_BITS bits, LSB first. Each bit lasts CLKS_PER_BIT cycles. After the last bit, go to PARITY if PARITY_MODE != 0, else to STOP.
- PARITY: parity_err = (XOR of data ^ parity bit) != (PARITY_MODE == 1). Odd parity requires the total count of 1s to be odd.
- STOP: STOP_BITS bit periods. frame_err is set if any stop-bit majority is 0.
- Frame completion (cycle C): the majority of the final stop bit is resolved at cnt = HALF+1. The FSM leaves STOP at that point and does not wait for the end of the bit, so resync is early.
- Break: data all 0, parity bit 0 (if present) and a stop bit 0. Then break = 1 and frame_err = 1. FSM -> BRK_WAIT, which stays until rxs = 1, then -> IDLE. Otherwise FSM -> IDLE at C.
- Output register, on the edge after C:
  - If o_RX_DV = 0, or (o_RX_DV = 1 and i_RX_Ready = 1 at C): load data and flags, and set o_RX_DV = 1.
  - Otherwise: drop the new frame, keep the held contents, and pulse o_Overrun for exactly 1 cycle.
- Handshake: o_RX_DV & i_RX_Ready at a non-completion edge clears o_RX_DV. Data and flags are stable while o_RX_DV = 1. Handshake coinciding with completion: DV stays 1 with the new frame.
- Latency: line edge of the final stop bit start -> o_RX_DV = 2 + HALF + 2 cycles.
- Widths: cnt is $clog2(CLKS_PER_BIT) bits; bit index is $clog2(DATA_BITS+1) bits.

Test Plan:
- CLKS_PER_BIT=16, 8N1, send 0xA5, then 0x3C with i_RX_Ready = 1 -> o_RX_Data = 0xA5 then 0x3C, each DV asserted for 1 cycle, all error flags 0.
- DATA_BITS=7, PARITY_MODE=2, send 0x55 with correct parity bit 0, then with the parity bit forced to 1 -> Parity_Err = 0, then Parity_Err = 1 with data 0x55.
- Line low for 3 cycles then high -> no DV, FSM back in IDLE. In a separate frame, a 1-cycle inverted spike at cnt = HALF in bit 2 of 0xA5 -> 0xA5 still received correctly.
- STOP_BITS=2, second stop bit driven 0 while sending 0x81 -> DV with data 0x81 and Frame_Err = 1, Break = 0. Line held low for 20 bit times -> Break = 1 and Frame_Err = 1. No further DV until the line returns high and a new start bit arrives.
- i_RX_Ready = 0, send 0x11 then 0x22 -> data held at 0x11 and o_Overrun pulses 1 cycle. Asserting ready then clears DV. A third frame, 0x33, is received normally.
- Pull i_Rst_L low during data bit 4 of a frame -> all outputs 0 immediately. The next full frame, 0x5A, is received correctly.
